// File: rtl/output_port_allocator.sv
// Per-output-port packet allocator: round-robin arbitration over five inputs, wormhole lock
// from header to tail, and credit-based flow control toward the downstream buffer.
module output_port_allocator #(
   parameter int unsigned CREDIT_MAX = 4,
   parameter int unsigned CW         = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          Req_N,
   input  logic          Req_E,
   input  logic          Req_W,
   input  logic          Req_S,
   input  logic          Req_L,
   input  logic          Tail_N,
   input  logic          Tail_E,
   input  logic          Tail_W,
   input  logic          Tail_S,
   input  logic          Tail_L,
   input  logic          Credit_in,
   output logic          Grant_N,
   output logic          Grant_E,
   output logic          Grant_W,
   output logic          Grant_S,
   output logic          Grant_L,
   output logic [4:0]    Xbar_sel,
   output logic          Valid_out,
   output logic [CW-1:0] Credit_cnt,
   output logic          Credit_err
);

   localparam logic       ST_IDLE   = 1'b0;
   localparam logic       ST_LOCKED = 1'b1;
   localparam logic [4:0] PORT_L    = 5'b10000;
   localparam logic [CW-1:0] CMAX   = CW'(CREDIT_MAX);
   localparam logic [CW-1:0] CONE   = CW'(1);

   logic          fsm_q, fsm_d;
   logic [4:0]    owner_q, owner_d;
   logic [4:0]    rr_q, rr_d;
   logic [CW-1:0] credit_q, credit_d;
   logic          err_q, err_d;

   // Bit order throughout: {L, S, W, E, N}; rotating left follows N->E->W->S->L->N.
   logic [4:0] req, tail, pick, cand, grant;
   logic       found, grant_any, tail_hit;

   assign req  = {Req_L, Req_S, Req_W, Req_E, Req_N};
   assign tail = {Tail_L, Tail_S, Tail_W, Tail_E, Tail_N};

   always_comb begin
      pick  = 5'b00000;
      found = 1'b0;
      cand  = rr_q;
      for (int k = 0; k < 5; k++) begin
         if (!found && |(cand & req)) begin
            pick  = cand;
            found = 1'b1;
         end
         cand = {cand[3:0], cand[4]};
      end
   end

   assign grant     = owner_q & req & {5{(fsm_q == ST_LOCKED) && (credit_q != '0)}};
   assign grant_any = |grant;
   assign tail_hit  = grant_any && |(owner_q & tail);

   always_comb begin
      fsm_d   = fsm_q;
      owner_d = owner_q;
      rr_d    = rr_q;
      if (fsm_q == ST_IDLE) begin
         if (found) begin
            owner_d = pick;
            fsm_d   = ST_LOCKED;
         end
      end else if (tail_hit) begin
         fsm_d   = ST_IDLE;
         owner_d = 5'b00000;
         rr_d    = {owner_q[3:0], owner_q[4]};
      end
   end

   always_comb begin
      credit_d = credit_q;
      err_d    = err_q;
      unique case ({Credit_in, grant_any})
         2'b10: begin
            // A credit with nothing in flight to account for it means downstream over-returned.
            if (credit_q == CMAX) err_d = 1'b1;
            else                  credit_d = credit_q + CONE;
         end
         2'b01:   credit_d = credit_q - CONE;
         default: credit_d = credit_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fsm_q    <= ST_IDLE;
         owner_q  <= 5'b00000;
         rr_q     <= PORT_L;
         credit_q <= CMAX;
         err_q    <= 1'b0;
      end else begin
         fsm_q    <= fsm_d;
         owner_q  <= owner_d;
         rr_q     <= rr_d;
         credit_q <= credit_d;
         err_q    <= err_d;
      end
   end

   assign {Grant_L, Grant_S, Grant_W, Grant_E, Grant_N} = grant;
   assign Xbar_sel   = owner_q;
   assign Valid_out  = grant_any;
   assign Credit_cnt = credit_q;
   assign Credit_err = err_q;

endmodule

// File: tb/tb_output_port_allocator.sv
// Directed bench for output_port_allocator: arbitration order, packet lock, credit stalls,
// credit overflow error and mid-packet reset.
module tb_output_port_allocator;

   logic       clk = 1'b0;
   logic       rst;
   logic       Req_N, Req_E, Req_W, Req_S, Req_L;
   logic       Tail_N, Tail_E, Tail_W, Tail_S, Tail_L;
   logic       Credit_in;
   logic       Grant_N, Grant_E, Grant_W, Grant_S, Grant_L;
   logic [4:0] Xbar_sel;
   logic       Valid_out;
   logic [2:0] Credit_cnt;
   logic       Credit_err;

   int checks = 0;
   int errors = 0;

   logic [4:0] gnt;
   assign gnt = {Grant_L, Grant_S, Grant_W, Grant_E, Grant_N};

   output_port_allocator #(.CREDIT_MAX(4), .CW(3)) dut (
      .clk        (clk),
      .rst        (rst),
      .Req_N      (Req_N),
      .Req_E      (Req_E),
      .Req_W      (Req_W),
      .Req_S      (Req_S),
      .Req_L      (Req_L),
      .Tail_N     (Tail_N),
      .Tail_E     (Tail_E),
      .Tail_W     (Tail_W),
      .Tail_S     (Tail_S),
      .Tail_L     (Tail_L),
      .Credit_in  (Credit_in),
      .Grant_N    (Grant_N),
      .Grant_E    (Grant_E),
      .Grant_W    (Grant_W),
      .Grant_S    (Grant_S),
      .Grant_L    (Grant_L),
      .Xbar_sel   (Xbar_sel),
      .Valid_out  (Valid_out),
      .Credit_cnt (Credit_cnt),
      .Credit_err (Credit_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Vectors are {L, S, W, E, N}.
   task automatic drive(input logic [4:0] r, input logic [4:0] t, input logic c);
      {Req_L, Req_S, Req_W, Req_E, Req_N}      = r;
      {Tail_L, Tail_S, Tail_W, Tail_E, Tail_N} = t;
      Credit_in = c;
      #1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(5'b00000, 5'b00000, 1'b0);
      step();
      rst = 1'b0;
   endtask

   logic [4:0] rr_exp [6];

   initial begin
      rr_exp[0] = 5'b10000; rr_exp[1] = 5'b00001; rr_exp[2] = 5'b00010;
      rr_exp[3] = 5'b00100; rr_exp[4] = 5'b01000; rr_exp[5] = 5'b10000;

      // Reset state
      rst = 1'b1;
      drive(5'b00000, 5'b00000, 1'b0);
      step();
      step();
      rst = 1'b0;
      #1;
      check("rst_xbar", 8'(Xbar_sel), 8'h00);
      check("rst_gnt", 8'(gnt), 8'h00);
      check("rst_valid", 8'(Valid_out), 8'h0);
      check("rst_cnt", 8'(Credit_cnt), 8'd4);
      check("rst_err", 8'(Credit_err), 8'h0);

      // N and L request together; L wins a 3-flit packet, then N
      drive(5'b10001, 5'b00000, 1'b0);
      check("t1_idle_gnt", 8'(gnt), 8'h00);
      step();
      check("t1_xbar_l", 8'(Xbar_sel), 8'b10000);
      check("t1_gnt_l0", 8'(gnt), 8'b10000);
      check("t1_cnt0", 8'(Credit_cnt), 8'd4);
      step();
      check("t1_gnt_l1", 8'(gnt), 8'b10000);
      check("t1_cnt1", 8'(Credit_cnt), 8'd3);
      step();
      drive(5'b10001, 5'b10000, 1'b0);
      check("t1_gnt_l2", 8'(gnt), 8'b10000);
      check("t1_cnt2", 8'(Credit_cnt), 8'd2);
      step();
      drive(5'b00001, 5'b00000, 1'b0);
      check("t1_bubble_gnt", 8'(gnt), 8'h00);
      check("t1_bubble_xbar", 8'(Xbar_sel), 8'h00);
      check("t1_cnt3", 8'(Credit_cnt), 8'd1);
      step();
      check("t1_xbar_n", 8'(Xbar_sel), 8'b00001);
      check("t1_gnt_n", 8'(gnt), 8'b00001);
      step();
      check("t1_stall_gnt", 8'(gnt), 8'h00);
      check("t1_stall_valid", 8'(Valid_out), 8'h0);
      check("t1_stall_xbar", 8'(Xbar_sel), 8'b00001);
      check("t1_cnt4", 8'(Credit_cnt), 8'd0);

      // Round-robin fairness with single-flit packets and a credit every cycle
      do_reset();
      drive(5'b11111, 5'b11111, 1'b1);
      for (int i = 0; i < 6; i++) begin
         check("rr_idle_gnt", 8'(gnt), 8'h00);
         step();
         check("rr_gnt", 8'(gnt), 8'(rr_exp[i]));
         check("rr_cnt", 8'(Credit_cnt), 8'd4);
         step();
      end

      // Credit stall on owner E
      do_reset();
      drive(5'b00010, 5'b00000, 1'b0);
      step();
      for (int i = 0; i < 4; i++) begin
         check("cs_gnt_e", 8'(gnt), 8'b00010);
         check("cs_cnt", 8'(Credit_cnt), 8'(4 - i));
         step();
      end
      check("cs_stall_gnt", 8'(gnt), 8'h00);
      check("cs_stall_xbar", 8'(Xbar_sel), 8'b00010);
      check("cs_stall_cnt", 8'(Credit_cnt), 8'd0);
      drive(5'b00010, 5'b00000, 1'b1);
      check("cs_pulse_gnt", 8'(gnt), 8'h00);
      step();
      drive(5'b00010, 5'b00000, 1'b0);
      check("cs_ret_cnt", 8'(Credit_cnt), 8'd1);
      check("cs_ret_gnt", 8'(gnt), 8'b00010);
      step();
      check("cs_after_cnt", 8'(Credit_cnt), 8'd0);
      check("cs_after_gnt", 8'(gnt), 8'h00);

      // Owner W drops its request mid-packet while S waits
      do_reset();
      drive(5'b00100, 5'b00000, 1'b0);
      step();
      drive(5'b01100, 5'b00000, 1'b0);
      check("w_gnt0", 8'(gnt), 8'b00100);
      step();
      drive(5'b01000, 5'b00000, 1'b0);
      for (int i = 0; i < 2; i++) begin
         check("w_drop_gnt", 8'(gnt), 8'h00);
         check("w_drop_xbar", 8'(Xbar_sel), 8'b00100);
         step();
      end
      drive(5'b01100, 5'b00100, 1'b0);
      check("w_tail_gnt", 8'(gnt), 8'b00100);
      step();
      drive(5'b01000, 5'b00000, 1'b0);
      check("w_bubble_gnt", 8'(gnt), 8'h00);
      step();
      check("s_xbar", 8'(Xbar_sel), 8'b01000);
      check("s_gnt", 8'(gnt), 8'b01000);
      check("s_cnt", 8'(Credit_cnt), 8'd2);

      // Credit overflow while idle
      do_reset();
      drive(5'b00000, 5'b00000, 1'b1);
      step();
      drive(5'b00000, 5'b00000, 1'b0);
      check("ovf_cnt", 8'(Credit_cnt), 8'd4);
      check("ovf_err", 8'(Credit_err), 8'h1);
      step();
      step();
      check("ovf_sticky", 8'(Credit_err), 8'h1);
      do_reset();
      #1;
      check("ovf_cleared", 8'(Credit_err), 8'h0);

      // Reset in the middle of a 4-flit packet
      do_reset();
      drive(5'b00001, 5'b00000, 1'b0);
      step();
      check("mr_gnt0", 8'(gnt), 8'b00001);
      step();
      check("mr_gnt1", 8'(gnt), 8'b00001);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      drive(5'b10010, 5'b00010, 1'b0);
      check("mr_xbar", 8'(Xbar_sel), 8'h00);
      check("mr_gnt", 8'(gnt), 8'h00);
      check("mr_cnt", 8'(Credit_cnt), 8'd4);
      step();
      // L outranks E only if the pointer returned to L
      check("mr_rr_l", 8'(Xbar_sel), 8'b10000);
      drive(5'b00010, 5'b00010, 1'b0);
      check("mr_l_stall", 8'(gnt), 8'h00);
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      check("mr_e_xbar", 8'(Xbar_sel), 8'b00010);
      check("mr_e_gnt", 8'(gnt), 8'b00010);
      step();
      drive(5'b00000, 5'b00000, 1'b0);
      check("mr_e_done", 8'(Xbar_sel), 8'h00);
      check("mr_e_cnt", 8'(Credit_cnt), 8'd3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
